// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port block memory between the
// instruction-cache and data-cache miss paths, holding the strobe for LATENCY cycles.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_req,
  input  logic [WORD_SIZE-1:0]     i_addr,
  output logic [4*WORD_SIZE-1:0]   i_rdata,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [WORD_SIZE-1:0]     d_addr,
  input  logic [4*WORD_SIZE-1:0]   d_wdata,
  output logic [4*WORD_SIZE-1:0]   d_rdata,
  output logic                     d_done,
  output logic                     m_readM,
  output logic                     m_writeM,
  output logic [WORD_SIZE-1:0]     m_address,
  output logic [4*WORD_SIZE-1:0]   m_wdata,
  input  logic [4*WORD_SIZE-1:0]   m_rdata,
  output logic [1:0]               owner
);

  localparam int unsigned BLOCK_W = 4 * WORD_SIZE;
  localparam int unsigned CNT_W   = 3;
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic                 last_i_q, last_i_d;
  logic [1:0]           owner_d;
  logic [BLOCK_W-1:0]   i_rdata_d, d_rdata_d;
  logic                 i_done_d, d_done_d;
  logic                 read_d, write_d;
  logic [WORD_SIZE-1:0] address_d;
  logic [BLOCK_W-1:0]   m_wdata_d;
  logic                 grant_d;

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    last_i_d  = last_i_q;
    owner_d   = owner;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    address_d = '0;
    m_wdata_d = '0;
    grant_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side not served last wins.
          grant_d = d_req && (!i_req || last_i_q);
          if (grant_d) begin
            addr_d  = d_addr & ALIGN_MASK;
            we_d    = d_we;
            wdata_d = d_wdata;
            owner_d = 2'b10;
          end else begin
            addr_d  = i_addr & ALIGN_MASK;
            we_d    = 1'b0;
            wdata_d = '0;
            owner_d = 2'b01;
          end
          cnt_d     = '0;
          state_d   = ACCESS;
          read_d    = !we_d;
          write_d   = we_d;
          address_d = addr_d;
          m_wdata_d = we_d ? wdata_d : '0;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          i_done_d = owner[0];
          d_done_d = owner[1];
          if (!we_q) begin
            if (owner[1]) d_rdata_d = m_rdata;
            else          i_rdata_d = m_rdata;
          end
        end else begin
          read_d    = !we_q;
          write_d   = we_q;
          address_d = addr_q;
          m_wdata_d = we_q ? wdata_q : '0;
        end
      end

      DONE: begin
        last_i_d = owner[0];
        owner_d  = 2'b00;
        state_d  = IDLE;
      end

      default: begin
        owner_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      last_i_q  <= 1'b1;
      owner     <= 2'b00;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      last_i_q  <= last_i_d;
      owner     <= owner_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      i_done    <= i_done_d;
      d_done    <= d_done_d;
      m_readM   <= read_d;
      m_writeM  <= write_d;
      m_address <= address_d;
      m_wdata   <= m_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected accesses checked by a
// negedge monitor, plus cycle-exact checks in the stimulus sequence.
module tb_mem_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [W-1:0]  i_addr, d_addr;
  logic [63:0]   d_wdata;
  logic [63:0]   i_rdata, d_rdata, m_wdata, m_rdata;
  logic          i_done, d_done, m_readM, m_writeM;
  logic [W-1:0]  m_address;
  logic [1:0]    owner;

  typedef struct {
    bit          d;
    bit          we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } sb_t;

  sb_t         q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  logic [63:0] exp_i = '0;
  logic [63:0] exp_d = '0;

  mem_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] blk(input logic [15:0] a);
    if (a == 16'h0024) return 64'h9023_0001_FFFF_0000;
    return {a, ~a, a ^ 16'h5a5a, 16'hc3c3};
  endfunction

  // Memory model: read data only present while the read strobe is up.
  assign m_rdata = m_readM ? blk(m_address) : 64'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit d, input bit we, input logic [15:0] addr, input logic [63:0] wd);
    sb_t e;
    e.d = d; e.we = we; e.addr = addr & 16'hfffc; e.wdata = we ? wd : 64'h0;
    if (we) e.rdata = exp_d;
    else begin
      e.rdata = blk(e.addr);
      if (d) exp_d = e.rdata; else exp_i = e.rdata;
    end
    q.push_back(e);
  endtask

  task automatic wait_done(input bit keep, output int k, output bit side_d);
    k = 0; side_d = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        k = c; side_d = d_done;
        if (!keep) begin
          if (d_done) d_req = 0; else i_req = 0;
        end
        return;
      end
    end
  endtask

  // Scoreboard monitor: every strobe cycle and done pulse is checked against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_overlap", 64'(m_readM & m_writeM), 64'h0);
      if (!m_readM && !m_writeM) begin
        chk("idle_addr", 64'(m_address), 64'h0);
        chk("idle_wdata", m_wdata, 64'h0);
      end else begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++; $error("FAIL strobe_unexpected observed=%0d expected=%0d", q.size(), 1);
        end
        if (q.size() != 0) begin
          chk("sb_addr", 64'(m_address), 64'(q[0].addr));
          chk("sb_kind", 64'(m_writeM), 64'(q[0].we));
          if (q[0].we) chk("sb_wdata", m_wdata, q[0].wdata);
        end
      end
      if (i_done || d_done) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++; $error("FAIL done_unexpected observed=%0d expected=%0d", q.size(), 1);
        end
        if (q.size() != 0) begin
          sb_t e;
          e = q.pop_front();
          chk("sb_d_done", 64'(d_done), 64'(e.d));
          chk("sb_i_done", 64'(i_done), 64'(!e.d));
          if (e.d) chk("sb_d_rdata", d_rdata, e.rdata);
          else     chk("sb_i_rdata", i_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int  k;
    bit  sd;
    reset_n = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_strobes", 64'({m_readM, m_writeM, i_done, d_done}), 64'h0);
    chk("rst_addr", 64'(m_address), 64'h0);
    chk("rst_rdata", i_rdata | d_rdata | m_wdata, 64'h0);
    reset_n = 1;
    mon_en  = 1;

    // Simultaneous requests right after reset: D first, then I.
    @(negedge clk);
    d_we = 0; d_addr = 16'h0030; i_addr = 16'h0025;
    d_req = 1; i_req = 1;
    push(1, 0, 16'h0030, 64'h0);
    push(0, 0, 16'h0025, 64'h0);
    wait_done(0, k, sd);
    chk("tie_first_side", 64'(sd), 64'h1);
    chk("tie_first_lat", 64'(k), 64'(LAT + 1));
    wait_done(0, k, sd);
    chk("tie_second_side", 64'(sd), 64'h0);
    chk("tie_second_lat", 64'(k), 64'(LAT + 2));

    // Continuous contention for four accesses: D, I, D, I.
    @(negedge clk);
    d_addr = 16'h0050; i_addr = 16'h0061;
    d_req = 1; i_req = 1;
    for (int n = 0; n < 4; n++) push((n % 2) == 0, 0, (n % 2) == 0 ? 16'h0050 : 16'h0061, 64'h0);
    for (int n = 0; n < 4; n++) begin
      wait_done(n != 3, k, sd);
      chk("rr_side", 64'(sd), 64'((n % 2) == 0));
      chk("rr_lat", 64'(k), 64'(n == 0 ? LAT + 1 : LAT + 2));
    end
    d_req = 0;

    // Single I read with cycle-exact checks.
    @(negedge clk);
    i_addr = 16'h0025; i_req = 1;
    push(0, 0, 16'h0025, 64'h0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk("i_rd_readM", 64'(m_readM), 64'h1);
      chk("i_rd_owner", 64'(owner), 64'h1);
      chk("i_rd_addr", 64'(m_address), 64'h0024);
      chk("i_rd_done_early", 64'(i_done), 64'h0);
    end
    @(negedge clk);
    chk("i_rd_done", 64'(i_done), 64'h1);
    chk("i_rd_strobe_off", 64'(m_readM), 64'h0);
    chk("i_rd_owner_done", 64'(owner), 64'h1);
    chk("i_rd_data", i_rdata, 64'h9023_0001_FFFF_0000);
    i_req = 0;
    @(negedge clk);
    chk("i_rd_owner_idle", 64'(owner), 64'h0);
    chk("i_rd_done_pulse", 64'(i_done), 64'h0);
    chk("i_rd_hold", i_rdata, 64'h9023_0001_FFFF_0000);

    // D read whose address changes mid-access: latched address must hold.
    d_we = 0; d_addr = 16'h0010; d_req = 1;
    push(1, 0, 16'h0010, 64'h0);
    @(negedge clk);
    d_addr = 16'h0020;
    chk("d_rd_addr_latched", 64'(m_address), 64'h0010);
    wait_done(0, k, sd);
    chk("d_rd_lat", 64'(k), 64'(LAT));
    chk("d_rd_data", d_rdata, blk(16'h0010));

    // D write: write strobe only, d_rdata untouched.
    @(negedge clk);
    d_we = 1; d_addr = 16'h0010; d_wdata = 64'h1111_2222_3333_4444; d_req = 1;
    push(1, 1, 16'h0010, 64'h1111_2222_3333_4444);
    @(negedge clk);
    chk("d_wr_writeM", 64'(m_writeM), 64'h1);
    chk("d_wr_readM", 64'(m_readM), 64'h0);
    chk("d_wr_wdata", m_wdata, 64'h1111_2222_3333_4444);
    wait_done(0, k, sd);
    chk("d_wr_lat", 64'(k), 64'(LAT));
    chk("d_wr_rdata_kept", d_rdata, blk(16'h0010));
    d_we = 0;

    // Reset during the second ACCESS cycle aborts without a done pulse.
    @(negedge clk);
    i_addr = 16'h0044; i_req = 1;
    push(0, 0, 16'h0044, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_strobe", 64'(m_readM), 64'h1);
    reset_n = 0; i_req = 0;
    @(negedge clk);
    chk("abort_strobes", 64'({m_readM, m_writeM}), 64'h0);
    chk("abort_owner", 64'(owner), 64'h0);
    chk("abort_dones", 64'({i_done, d_done}), 64'h0);
    q.delete();
    exp_i = '0; exp_d = '0;
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("abort_rdata_cleared", i_rdata, 64'h0);

    // Fresh request after the abort completes normally.
    i_addr = 16'h0048; i_req = 1;
    push(0, 0, 16'h0048, 64'h0);
    wait_done(0, k, sd);
    chk("fresh_side", 64'(sd), 64'h0);
    chk("fresh_lat", 64'(k), 64'(LAT + 1));
    chk("fresh_data", i_rdata, blk(16'h0048));

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares one single-port, 4-word-block memory between the instruction-cache and data-cache miss paths. It accepts level requests from both sides, grants the port round-robin, and drives the memory read or write strobe for a fixed latency window. It returns the block with a one-cycle completion pulse. It sits between the two caches and the block memory, replacing the separate instruction and data memory ports with a single shared port.

## Interface
- WORD_SIZE, 16, word width in bits; a block is 4*WORD_SIZE.
- LATENCY, 2, cycles the memory strobe must be held before the read data is valid or the write is committed (legal range 1..7).
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_req  in  1  instruction-side block read request (level).
- i_addr  in  WORD_SIZE  instruction word address.
- i_rdata  out  4*WORD_SIZE  returned instruction block.
- i_done  out  1  one-cycle completion pulse for the instruction side.
- d_req  in  1  data-side request (level).
- d_we  in  1  data-side request is a write when 1.
- d_addr  in  WORD_SIZE  data word address.
- d_wdata  in  4*WORD_SIZE  data block to write.
- d_rdata  out  4*WORD_SIZE  returned data block.
- d_done  out  1  one-cycle completion pulse for the data side.
- m_readM  out  1  memory read strobe.
- m_writeM  out  1  memory write strobe.
- m_address  out  WORD_SIZE  block-aligned memory address.
- m_wdata  out  4*WORD_SIZE  memory write block.
- m_rdata  in  4*WORD_SIZE  memory read block.
- owner  out  2  one-hot current owner: 01 = I, 10 = D, 00 = none.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset forces IDLE.
- Reset values: all outputs 0, counter 0, last-served pointer = I, so D wins the first tie.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request high: grant that requester.
  - Both high: grant the requester not served last.
  - On a grant: latch address (low 2 bits forced to 00), latch we, latch wdata (data side only; instruction side is always a read), set owner, clear counter, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Drive m_readM (read) or m_writeM (write) = 1, m_address = latched aligned address, m_wdata = latched wdata on writes.
  - The counter increments each cycle.
  - In the cycle where counter = LATENCY-1: a read captures m_rdata into the owner's rdata register; then go to DONE.
- DONE:
  - Strobes are 0.
  - The owner's done output is 1 for exactly this cycle; the owner's rdata is valid.
  - Update the last-served pointer; go to IDLE.
  - d_rdata is unchanged on a write.
- m_address and m_wdata are 0 outside ACCESS. m_readM and m_writeM are never both 1.
- i_rdata and d_rdata hold their value until the next read completion for that side.
- Requester contract: keep req, addr, we and wdata stable from raising req until done is seen; drop req on the edge that samples done.
- If req is still high in the following IDLE cycle, it is treated as a new request.
- The arbiter never revokes a grant. Changes to the latched fields after the grant are ignored.
- Reset mid-operation (reset_n low in ACCESS or DONE): next cycle is IDLE with strobes, done and owner = 0. No done pulse is issued for the aborted access.

## Timing
- All outputs are registered (driven from state or flops); there is no combinational path from req to m_* outputs.
- Request high in an IDLE cycle t gives:
  - strobe high for cycles t+1 .. t+LATENCY;
  - done high in cycle t+LATENCY+1;
  - IDLE again in t+LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Worst-case wait for a requester under continuous contention is one full access of the other side.

## Test plan
- Single I read, LATENCY=2, i_addr=0x0025, memory block 0x9023_0001_FFFF_0000 → m_address=0x0024, m_readM high in cycles 1–2, i_done in cycle 3, i_rdata=0x9023000 1FFFF0000 held afterwards, owner=01 in cycles 1–3.
- D write, d_addr=0x0010, d_wdata=0x1111_2222_3333_4444 → m_writeM high in cycles 1–2 with m_wdata equal to that block, m_readM=0 throughout, d_done in cycle 3, d_rdata unchanged.
- i_req and d_req rise together right after reset → D served first (done in cycle 3), then I (grant in cycle 4, done in cycle 7).
- Both held continuously for 4 accesses → grants alternate D, I, D, I with no strobe overlap.
- reset_n pulled low during the second ACCESS cycle → next cycle strobes, owner, i_done and d_done = 0; no done pulse is issued; a fresh request afterwards completes normally.
- Change d_addr from 0x0010 to 0x0020 during ACCESS → m_address stays 0x0010 for the whole access.
